// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address+R/W phase, then read-out or write-in data phase.
// Moore machine; every enable is decoded from the current state alone.
module spi_fsm #(
   parameter int unsigned width = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclkPosEdge,
   input  logic       sclkNegEdge,
   input  logic       cs,
   input  logic       shiftRegOutP0,
   output logic       addrWe,
   output logic       srWe,
   output logic       dmWe,
   output logic       misoBufe,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GET_ADDR    = 3'd1,
      GOT_ADDR    = 3'd2,
      READ_LOAD   = 3'd3,
      READ_SEND   = 3'd4,
      WRITE_GET   = 3'd5,
      WRITE_STORE = 3'd6,
      DONE        = 3'd7
   } state_t;

   localparam logic [3:0] LAST = 4'(width - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The width-th edge moves on instead of incrementing, so cnt_q stays below width.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:        state_d = GET_ADDR;
         GET_ADDR:
            if (sclkPosEdge) begin
               if (cnt_q == LAST) state_d = GOT_ADDR;
               else               cnt_d   = cnt_q + 4'd1;
            end
         GOT_ADDR:    state_d = shiftRegOutP0 ? READ_LOAD : WRITE_GET;
         READ_LOAD:   state_d = READ_SEND;
         READ_SEND:
            if (sclkNegEdge) begin
               if (cnt_q == LAST) state_d = DONE;
               else               cnt_d   = cnt_q + 4'd1;
            end
         WRITE_GET:
            if (sclkPosEdge) begin
               if (cnt_q == LAST) state_d = WRITE_STORE;
               else               cnt_d   = cnt_q + 4'd1;
            end
         WRITE_STORE: state_d = DONE;
         DONE:        state_d = DONE;
         default:     state_d = IDLE;
      endcase
      if (cs) state_d = IDLE;
      if (state_d != state_q) cnt_d = '0;
   end

   always_comb begin
      addrWe   = 1'b0;
      srWe     = 1'b0;
      dmWe     = 1'b0;
      misoBufe = 1'b0;
      unique case (state_q)
         GOT_ADDR:    addrWe   = 1'b1;
         READ_LOAD:   srWe     = 1'b1;
         READ_SEND:   misoBufe = 1'b1;
         WRITE_STORE: dmWe     = 1'b1;
         default:     ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_spi_fsm.sv
// Bench for spi_fsm: directed transactions with literal expectations, then random inputs
// checked every cycle against a pulses-remaining transaction model.
module tb_spi_fsm;

   localparam int W = 8;
   localparam logic [3:0] A = 4'b1000, S = 4'b0100, D = 4'b0010, M = 4'b0001;

   logic       clk = 1'b0;
   logic       reset = 1'b1, sclkPosEdge = 1'b0, sclkNegEdge = 1'b0, cs = 1'b1, shiftRegOutP0 = 1'b0;
   logic       addrWe, srWe, dmWe, misoBufe;
   logic [2:0] state;

   spi_fsm #(.width(W)) dut (
      .clk(clk), .reset(reset), .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge),
      .cs(cs), .shiftRegOutP0(shiftRegOutP0), .addrWe(addrWe), .srWe(srWe),
      .dmWe(dmWe), .misoBufe(misoBufe), .state(state)
   );

   always #5 clk = ~clk;

   // Transaction model: stage number plus edges still required to finish the phase.
   int m_stage = 0;
   int m_left  = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_stage = 0;
         m_left  = 0;
      end else if (cs) begin
         m_stage = 0;
      end else begin
         case (m_stage)
            0: begin m_stage = 1; m_left = W; end
            1: if (sclkPosEdge) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_stage = 2;
               end
            2: begin
                  m_stage = shiftRegOutP0 ? 3 : 5;
                  m_left  = W;
               end
            3: begin m_stage = 4; m_left = W; end
            4: if (sclkNegEdge) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_stage = 7;
               end
            5: if (sclkPosEdge) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_stage = 6;
               end
            6: m_stage = 7;
            default: m_stage = 7;
         endcase
      end
   end

   int         errors = 0;
   int         checks = 0;
   logic       lit_en = 1'b0;
   logic [2:0] lit_state = '0;
   logic [3:0] lit_outs = '0;

   always @(negedge clk) begin
      logic [3:0] outs, mo;
      outs = {addrWe, srWe, dmWe, misoBufe};
      mo   = {m_stage == 2, m_stage == 3, m_stage == 6, m_stage == 4};
      checks++;
      if (state !== 3'(m_stage)) begin
         errors++;
         $display("FAIL model_state t=%0t got=%0d want=%0d", $time, state, m_stage);
      end
      checks++;
      if (outs !== mo) begin
         errors++;
         $display("FAIL model_outs t=%0t got=%b want=%b", $time, outs, mo);
      end
      checks++;
      if ($countones(outs) > 1) begin
         errors++;
         $display("FAIL onehot_enables t=%0t got=%b want=at most one set", $time, outs);
      end
      if (lit_en) begin
         checks++;
         if (state !== lit_state) begin
            errors++;
            $display("FAIL lit_state t=%0t got=%0d want=%0d", $time, state, lit_state);
         end
         checks++;
         if (outs !== lit_outs) begin
            errors++;
            $display("FAIL lit_outs t=%0t got=%b want=%b", $time, outs, lit_outs);
         end
      end
   end

   task automatic drive(input logic r, c, p, n, b);
      reset = r; cs = c; sclkPosEdge = p; sclkNegEdge = n; shiftRegOutP0 = b;
      @(negedge clk);
      #1;
      lit_en = 1'b0;
   endtask

   // Apply inputs for one clk; the outputs after that clk must equal es/eo.
   task automatic step(input logic r, c, p, n, b, input logic [2:0] es, input logic [3:0] eo);
      lit_en = 1'b1; lit_state = es; lit_outs = eo;
      drive(r, c, p, n, b);
   endtask

   task automatic addr_phase();
      step(0, 0, 0, 0, 0, 3'd1, 4'b0);
      for (int i = 0; i < W; i++) begin
         step(0, 0, 1, 0, 0, (i == W - 1) ? 3'd2 : 3'd1, (i == W - 1) ? A : 4'b0);
         if (i != W - 1) step(0, 0, 0, 0, 0, 3'd1, 4'b0);
      end
   endtask

   initial begin
      step(1, 1, 0, 0, 0, 3'd0, 4'b0);
      step(1, 0, 1, 1, 1, 3'd0, 4'b0);
      step(0, 1, 1, 0, 0, 3'd0, 4'b0);

      // write transaction, then DONE hold
      addr_phase();
      step(0, 0, 0, 0, 0, 3'd5, 4'b0);
      for (int i = 0; i < W; i++)
         step(0, 0, 1, 1, 0, (i == W - 1) ? 3'd6 : 3'd5, (i == W - 1) ? D : 4'b0);
      step(0, 0, 0, 0, 0, 3'd7, 4'b0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 3'd7, 4'b0);
      step(0, 1, 0, 0, 0, 3'd0, 4'b0);

      // read transaction with posedges ignored while sending
      addr_phase();
      step(0, 0, 0, 0, 1, 3'd3, S);
      step(0, 0, 1, 0, 0, 3'd4, M);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 3'd4, M);
      for (int i = 0; i < W; i++)
         step(0, 0, 1, 1, 0, (i == W - 1) ? 3'd7 : 3'd4, (i == W - 1) ? 4'b0 : M);
      step(0, 1, 0, 0, 0, 3'd0, 4'b0);

      // abort, negedge filtering in GET_ADDR, fresh full address needed
      step(0, 0, 0, 0, 0, 3'd1, 4'b0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 3'd1, 4'b0);
      for (int i = 0; i < W; i++) step(0, 0, 0, 1, 0, 3'd1, 4'b0);
      step(0, 1, 1, 0, 0, 3'd0, 4'b0);
      step(0, 0, 0, 0, 0, 3'd1, 4'b0);
      for (int i = 0; i < W; i++)
         step(0, 0, 1, 0, 0, (i == W - 1) ? 3'd2 : 3'd1, (i == W - 1) ? A : 4'b0);

      // reset in WRITE_GET after 5 edges
      step(0, 0, 0, 0, 0, 3'd5, 4'b0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 3'd5, 4'b0);
      step(1, 0, 1, 0, 0, 3'd0, 4'b0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 3'd0, 4'b0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 249) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
